// File: rtl/pong_game_ctrl_pkg.sv
// rtl/pong_game_ctrl_pkg.sv - shared pong table geometry, game defaults and FSM encoding
package pong_game_ctrl_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int PADDLE_H  = 64;
    localparam int BALL_SIZE = 8;

    localparam int WIN_SCORE_DEF    = 7;
    localparam int SERVE_FRAMES_DEF = 60;
    localparam int POINT_FRAMES_DEF = 30;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_POINT    = 3'd3,
        ST_GAMEOVER = 3'd4
    } game_state_e;

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop button synchronizer with registered rising-edge pulse
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic sync_q1;
    logic sync_q2;
    logic sync_q3;

    // pulse is registered so it lags the raw button by exactly three clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_q3 <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
            pulse   <= sync_q2 & ~sync_q3;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong match sequencer: serve, play, point, scoring and game over
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int POINT_FRAMES = POINT_FRAMES_DEF,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vblank,
    input  logic               start_btn,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               ball_run,
    output logic               ball_center,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               point_flash,
    output logic               game_over,
    output logic               winner
);

    localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_CNT = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]   POINT_CNT = CNT_W'(POINT_FRAMES);

    game_state_e        state_q;
    game_state_e        state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [SCORE_W-1:0] score_left_d;
    logic [SCORE_W-1:0] score_right_d;
    logic               serve_dir_d;
    logic               winner_d;
    logic               vblank_d;
    logic               frame_tick;
    logic               start_pulse;

    btn_sync_edge u_start_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (start_btn),
        .pulse (start_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_d <= 1'b0;
        end else begin
            vblank_d <= vblank;
        end
    end

    assign frame_tick = vblank & ~vblank_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        score_left_d  = score_left;
        score_right_d = score_right;
        serve_dir_d   = serve_dir;
        winner_d      = winner;
        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    state_d = ST_SERVE;
                    cnt_d   = SERVE_CNT;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == '0) begin
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                // simultaneous misses are a dead ball: replay without scoring
                if (miss_left || miss_right) begin
                    state_d = ST_POINT;
                    cnt_d   = POINT_CNT;
                    if (miss_left && !miss_right) begin
                        score_right_d = score_right + 1'b1;
                        serve_dir_d   = 1'b0;
                    end else if (miss_right && !miss_left) begin
                        score_left_d = score_left + 1'b1;
                        serve_dir_d  = 1'b1;
                    end
                end
            end
            ST_POINT: begin
                if (frame_tick) begin
                    if (cnt_q == '0) begin
                        if ((score_left == WIN_S) || (score_right == WIN_S)) begin
                            state_d  = ST_GAMEOVER;
                            winner_d = (score_right == WIN_S);
                        end else begin
                            state_d = ST_SERVE;
                            cnt_d   = SERVE_CNT;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_GAMEOVER: begin
                if (start_pulse) begin
                    state_d       = ST_SERVE;
                    cnt_d         = SERVE_CNT;
                    score_left_d  = '0;
                    score_right_d = '0;
                    serve_dir_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // outputs decode the next state so they switch on the same edge as the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            score_left  <= '0;
            score_right <= '0;
            serve_dir   <= 1'b1;
            winner      <= 1'b0;
            ball_run    <= 1'b0;
            ball_center <= 1'b1;
            point_flash <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            score_left  <= score_left_d;
            score_right <= score_right_d;
            serve_dir   <= serve_dir_d;
            winner      <= winner_d;
            ball_run    <= (state_d == ST_PLAY);
            ball_center <= (state_d == ST_IDLE) || (state_d == ST_SERVE) ||
                           (state_d == ST_GAMEOVER);
            point_flash <= (state_d == ST_POINT);
            game_over   <= (state_d == ST_GAMEOVER);
        end
    end

    score_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        (score_left <= WIN_S) && (score_right <= WIN_S));

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Match sequencer for the pong datapath. It starts play, enables and recentres the ball, detects missed balls, keeps both scores and declares a winner.
- Sits between the vga_controller vblank output, the ball and paddle blocks, and the score/overlay renderer.
- All timing is counted in frames, using the vblank rising edge as the frame tick, so game pacing is independent of pixel clock rate.

Parameters:
- SCORE_W, 4, width of each score counter.
- WIN_SCORE, 7, points needed to win; must be ≤ 2^SCORE_W-1.
- SERVE_FRAMES, 60, frames the ball is held at centre before launch.
- POINT_FRAMES, 30, frames the ball is frozen after a point (flash period).
- CNT_W, 8, frame delay counter width; must hold max(SERVE_FRAMES, POINT_FRAMES).

Ports:
- clk, input, 1, pixel clock domain shared with the ball block.
- rst_n, input, 1, asynchronous active-low reset.
- vblank, input, 1, level from vga_controller; its rising edge is the frame tick.
- start_btn, input, 1, raw board button, asynchronous.
- miss_left, input, 1, one-cycle pulse: ball passed the left table edge.
- miss_right, input, 1, one-cycle pulse: ball passed the right table edge.
- ball_run, output, 1, ball is allowed to move.
- ball_center, output, 1, ball is held at table centre.
- serve_dir, output, 1, launch direction: 0 = toward left, 1 = toward right.
- score_left, output, SCORE_W, left player score.
- score_right, output, SCORE_W, right player score.
- point_flash, output, 1, high during the POINT state.
- game_over, output, 1, high during the GAMEOVER state.
- winner, output, 1, 0 = left, 1 = right; valid only while game_over is high.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; scores = 0; serve_dir = 1; delay counter = 0; winner = 0.
  - ball_run = 0, ball_center = 1, point_flash = 0, game_over = 0.
- start_btn:
  - Passed through a 2-FF synchronizer, then a rising-edge detector.
  - start_pulse is one cycle long and lags the button by 3 clk.
- Frame tick:
  - frame_tick = vblank & ~vblank_d (registered). One cycle per frame.
- All outputs are registered and are pure functions of state. They change on the clock edge on which the state register updates.
- IDLE:
  - ball_center = 1.
  - On start_pulse: go to SERVE, load counter = SERVE_FRAMES.
- SERVE:
  - ball_center = 1, ball_run = 0.
  - Counter decrements on each frame_tick.
  - When the counter is 0 and a frame_tick occurs: go to PLAY.
  - SERVE_FRAMES = 0 gives PLAY on the first frame tick.
- PLAY:
  - ball_run = 1, ball_center = 0.
  - miss_left only: score_right += 1, serve_dir = 0 (serve toward the loser), go to POINT, counter = POINT_FRAMES.
  - miss_right only: score_left += 1, serve_dir = 1, go to POINT.
  - miss_left and miss_right in the same cycle: no score change, serve_dir unchanged, go to POINT.
  - Miss pulses are ignored in every state other than PLAY.
- POINT:
  - ball_run = 0, ball_center = 0 (ball frozen where it left), point_flash = 1.
  - Counter expires on a frame_tick, same rule as SERVE. Then:
    - If either score == WIN_SCORE: go to GAMEOVER, winner = (score_right == WIN_SCORE).
    - Otherwise: go to SERVE with counter = SERVE_FRAMES.
- GAMEOVER:
  - game_over = 1, ball_center = 1. Scores are held for display.
  - On start_pulse: clear both scores, serve_dir = 1, go to SERVE.
- Scores:
  - Never exceed WIN_SCORE, because GAMEOVER is entered before another increment is possible.
  - No wrap logic is required. An assertion checks score ≤ WIN_SCORE.
- start_pulse in SERVE, PLAY or POINT: ignored.
- Reset mid-game: immediate return to IDLE with scores cleared. Any in-flight miss pulse is lost.

Decomposition:
- Shared package / defs header:
  - Add the state encoding: IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, GAMEOVER = 4 (3 bits).
  - Add the WIN_SCORE, SERVE_FRAMES and POINT_FRAMES defaults next to the existing table geometry constants.
- One sub-module, btn_sync_edge: 2-FF synchronizer plus rising-edge pulse. It will be reused later for the paddle buttons.
- The FSM, frame-tick detector, counter and score registers stay in pong_game_ctrl.

Test Plan:
- Reset, then start_btn held 5 clk:
  - One start_pulse 3 clk after the press; SERVE entered.
  - With SERVE_FRAMES = 3, ball_run rises on the 4th vblank rising edge (counter loaded 3, PLAY on the tick seen at 0); ball_center = 1 throughout.
- In PLAY, pulse miss_left once:
  - score_right = 1, serve_dir = 0, point_flash = 1.
  - After POINT_FRAMES + 1 ticks: SERVE, then PLAY.
- miss_left and miss_right in the same cycle:
  - Scores unchanged, serve_dir unchanged, POINT entered.
- Miss pulses during SERVE and POINT, and start_btn during PLAY:
  - No state or score change.
- WIN_SCORE = 2, left misses twice:
  - After the second POINT: game_over = 1, winner = 1, score_right = 2, ball_run = 0.
  - start_btn then clears the scores to 0 and sets serve_dir = 1, entering SERVE.
- Assert rst_n low mid-PLAY with score_left = 3, asynchronous to clk:
  - Outputs return to reset values without waiting for a clock edge; state IDLE.
